// File: rtl/cpu_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_stim_sequencer
// Purpose  : Stimulus and capture sequencer for a CPU core. It pulses the CPU
//            reset, sweeps an address window while driving a data pattern,
//            and folds the returned data into a rotate-XOR signature.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_stim_sequencer #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 11,
    parameter int RST_CYCLES = 2,
    parameter int READ_LAT   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [1:0]        MODE,
    input  logic [ADDR_W-1:0] ADDR_FIRST,
    input  logic [ADDR_W-1:0] ADDR_LAST,
    input  logic [DATA_W-1:0] CONST_VAL,
    output logic              CPU_RST_N,
    output logic [ADDR_W-1:0] EXT_ADDR,
    output logic [DATA_W-1:0] DATA_I,
    input  logic [DATA_W-1:0] DATA_O,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] SIGNATURE,
    output logic [ADDR_W:0]   SAMPLES
);

    localparam int c_CNT_MAX = (RST_CYCLES > READ_LAT) ? RST_CYCLES : READ_LAT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_SAMP_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HOLD_RST = 3'd1,
        S_SWEEP    = 3'd2,
        S_DRAIN    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [1:0]          r_mode;
    logic [ADDR_W-1:0]   r_addr_last;
    logic [DATA_W-1:0]   r_const;
    logic [ADDR_W-1:0]   r_ext_addr;
    logic [DATA_W-1:0]   r_data_i;
    logic [DATA_W-1:0]   r_inc;
    logic [DATA_W-1:0]   r_walk;
    logic [READ_LAT-1:0] r_vld;
    logic [DATA_W-1:0]   r_sig;
    logic [c_SAMP_W-1:0] r_samples;
    logic                r_busy;
    logic                r_done;
    logic                r_cpu_rst_n;

    logic                w_accept;
    logic                w_load;
    logic                w_advance;
    logic                w_issue;
    logic [ADDR_W-1:0]   w_pat_addr;
    logic [DATA_W-1:0]   w_pat_inc;
    logic [DATA_W-1:0]   w_pat_walk;
    logic [DATA_W-1:0]   w_pattern;

    // State register plus a shared dwell counter for HOLD_RST and DRAIN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_state == S_HOLD_RST || r_state == S_DRAIN)
                r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_load    = 1'b0;
        w_advance = 1'b0;
        w_issue   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    w_next   = S_HOLD_RST;
                    w_accept = 1'b1;
                end
            end
            S_HOLD_RST: begin
                if (r_cnt == c_CNT_W'(RST_CYCLES - 1)) begin
                    w_next = S_SWEEP;
                    w_load = 1'b1;
                end
            end
            S_SWEEP: begin
                w_issue = 1'b1;
                if (r_ext_addr == r_addr_last)
                    w_next = S_DRAIN;
                else
                    w_advance = 1'b1;
            end
            S_DRAIN: begin
                if (r_cnt == c_CNT_W'(READ_LAT - 1))
                    w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Pattern for the step about to be issued: step 0 on load, step k+1 on advance
    always_comb begin
        w_pat_addr = w_load ? r_ext_addr : r_ext_addr + ADDR_W'(1);
        w_pat_inc  = w_load ? r_const : r_inc + DATA_W'(1);
        w_pat_walk = w_load ? DATA_W'(1) : {r_walk[DATA_W-2:0], r_walk[DATA_W-1]};
        case (r_mode)
            2'b00:   w_pattern = r_const;
            2'b01:   w_pattern = w_pat_inc;
            2'b10:   w_pattern = w_pat_walk;
            default: w_pattern = DATA_W'(w_pat_addr);
        endcase
    end

    // Latched configuration, address sweep and data pattern generators
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_mode      <= '0;
            r_addr_last <= '0;
            r_const     <= '0;
            r_ext_addr  <= '0;
            r_data_i    <= '0;
            r_inc       <= '0;
            r_walk      <= '0;
        end else if (w_accept) begin
            r_mode      <= MODE;
            r_addr_last <= ADDR_LAST;
            r_const     <= CONST_VAL;
            r_ext_addr  <= ADDR_FIRST;
        end else if (w_load || w_advance) begin
            r_ext_addr  <= w_pat_addr;
            r_inc       <= w_pat_inc;
            r_walk      <= w_pat_walk;
            r_data_i    <= w_pattern;
        end
    end

    // Read-latency tag pipeline and signature/sample capture
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_vld     <= '0;
            r_sig     <= '0;
            r_samples <= '0;
        end else begin
            r_vld <= (r_vld << 1) | READ_LAT'(w_issue);
            if (w_accept) begin
                r_sig     <= '0;
                r_samples <= '0;
            end else if (r_vld[READ_LAT-1]) begin
                r_sig     <= {r_sig[DATA_W-2:0], r_sig[DATA_W-1]} ^ DATA_O;
                r_samples <= r_samples + c_SAMP_W'(1);
            end
        end
    end

    // Registered status flags and CPU reset, decoded from the upcoming state
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cpu_rst_n <= 1'b0;
        end else begin
            r_busy      <= (w_next == S_HOLD_RST) || (w_next == S_SWEEP) ||
                           (w_next == S_DRAIN);
            r_done      <= (w_next == S_DONE);
            r_cpu_rst_n <= (w_next != S_HOLD_RST);
        end
    end

    assign CPU_RST_N = r_cpu_rst_n;
    assign EXT_ADDR  = r_ext_addr;
    assign DATA_I    = r_data_i;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign SIGNATURE = r_sig;
    assign SAMPLES   = r_samples;

endmodule
`default_nettype wire

// File: doc/cpu_stim_sequencer.md
Name: cpu_stim_sequencer

Overview:
Synthesizable stimulus and capture sequencer for exercising the CPU core on hardware or in simulation.
- Applies a programmable reset pulse to the CPU.
- Sweeps EXT_ADDR across a configurable address window.
- Drives DATA_I with a selectable pattern.
- Captures DATA_O after a fixed read latency into a running signature and a sample count.
- Sits between a host/control block and the CPU's CLK/RST/DATA_I/EXT_ADDR/DATA_O interface.

Parameters:
DATA_W, 16, width of DATA_I/DATA_O and the signature
ADDR_W, 11, width of EXT_ADDR
RST_CYCLES, 2, cycles CPU_RST_N is held low (must be >= 1)
READ_LAT, 1, cycles from EXT_ADDR drive to a valid DATA_O (must be >= 1)

Ports:
CLK  in  1  system clock, rising-edge
RST  in  1  asynchronous, active-low reset
START  in  1  single-cycle start request
MODE  in  2  DATA_I pattern: 00 constant, 01 incrementing, 10 walking-one, 11 address echo
ADDR_FIRST  in  ADDR_W  first sweep address
ADDR_LAST  in  ADDR_W  last sweep address (inclusive)
CONST_VAL  in  DATA_W  constant value / increment seed
CPU_RST_N  out  1  active-low reset to the CPU
EXT_ADDR  out  ADDR_W  address to the CPU
DATA_I  out  DATA_W  data to the CPU
DATA_O  in  DATA_W  data from the CPU
BUSY  out  1  high from accepted START until DONE
DONE  out  1  high in DONE state until the next accepted START
SIGNATURE  out  DATA_W  rotate-XOR signature of captured DATA_O
SAMPLES  out  ADDR_W+1  number of captured samples

Behaviour:
- One clock. RST is asynchronous and active-low. All state is cleared immediately on RST=0.
- Reset values: CPU_RST_N=0, EXT_ADDR=0, DATA_I=0, BUSY=0, DONE=0, SIGNATURE=0, SAMPLES=0, state=IDLE.
- CPU_RST_N is 1 in IDLE and DONE, so the CPU runs freely outside a sequence.
- States: IDLE, HOLD_RST, SWEEP, DRAIN, DONE.
- IDLE -> HOLD_RST on START=1.
  - On that edge: latch MODE, ADDR_FIRST, ADDR_LAST, CONST_VAL; clear SIGNATURE and SAMPLES; set BUSY=1, DONE=0.
  - EXT_ADDR <= ADDR_FIRST.
- HOLD_RST: CPU_RST_N=0 for exactly RST_CYCLES cycles, then -> SWEEP with CPU_RST_N=1.
- SWEEP: one address per cycle.
  - Issue EXT_ADDR=a and DATA_I=pattern(a, k), where k is the 0-based step index.
  - Pattern by mode:
    - 00: CONST_VAL.
    - 01: CONST_VAL+k, mod 2^DATA_W.
    - 10: 1 << (k mod DATA_W).
    - 11: zero-extended a.
  - After issuing ADDR_LAST -> DRAIN.
  - Address increment wraps mod 2^ADDR_W. If ADDR_LAST < ADDR_FIRST, the sweep wraps through max to 0 and continues to ADDR_LAST.
  - ADDR_FIRST == ADDR_LAST gives exactly one step.
- Capture pipeline:
  - A READ_LAT-deep valid shift register tags each issued step.
  - When a tag emerges: SIGNATURE <= {SIGNATURE[DATA_W-2:0], SIGNATURE[DATA_W-1]} ^ DATA_O, and SAMPLES <= SAMPLES+1.
- DRAIN: hold the last EXT_ADDR/DATA_I until the pipeline is empty (READ_LAT cycles), then -> DONE.
- DONE: BUSY=0, DONE=1. SIGNATURE and SAMPLES hold. START -> HOLD_RST with the same actions as from IDLE.
- START in HOLD_RST, SWEEP or DRAIN is ignored. Latched window and mode are unaffected.
- Input changes on MODE/ADDR_*/CONST_VAL mid-sequence have no effect.
- RST mid-sequence: immediate return to reset values. The pipeline is flushed and no partial capture is retained.
- SAMPLES at completion equals the number of addresses swept, from 1 to 2^ADDR_W. Its width is ADDR_W+1, so it never saturates.

Test Plan:
1. RST low 3 cycles, then high -> all outputs at reset values; CPU_RST_N=0 during reset, 1 afterwards; BUSY=0.
2. START, MODE=00, CONST_VAL=16'hFFFF, ADDR 0..3, DATA_O tied 16'hFFFF, READ_LAT=1 -> CPU_RST_N low exactly 2 cycles; EXT_ADDR 0,1,2,3 on consecutive cycles; SAMPLES=4; SIGNATURE=16'h0000; DONE=1.
3. MODE=11, ADDR 7FE..001 (wrap), DATA_O looped back from DATA_I -> EXT_ADDR sequence 7FE,7FF,000,001; SAMPLES=4; SIGNATURE matches the reference model.
4. MODE=10, ADDR 0..17, READ_LAT=3 -> DATA_I walks 0001..8000 then 0001,0002; DONE asserts exactly 3 cycles after the last address; SAMPLES=18.
5. START pulsed during SWEEP, and ADDR_LAST changed mid-sweep -> no restart; sweep ends at the originally latched ADDR_LAST.
6. RST dropped mid-SWEEP, then START -> outputs clear asynchronously; fresh sequence yields SAMPLES and SIGNATURE identical to an uninterrupted run.
